// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding buffer per functional unit,
// round-robin broadcast, age-based squash on branch flush.
module cdb_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [6:0]  alu_pd,
    input  logic [4:0]  alu_rob,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [6:0]  mem_pd,
    input  logic [4:0]  mem_rob,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    input  logic        br_valid,
    input  logic [6:0]  br_pd,
    input  logic [4:0]  br_rob,
    input  logic [31:0] br_data,
    output logic        br_ready,
    input  logic        flush_valid,
    input  logic [4:0]  flush_tag,
    input  logic [4:0]  rob_head,
    output logic        cdb_valid,
    output logic [6:0]  cdb_pd,
    output logic [4:0]  cdb_rob,
    output logic [31:0] cdb_data,
    output logic [1:0]  cdb_src
);

    typedef struct packed {
        logic [6:0]  pd;
        logic [4:0]  rob;
        logic [31:0] data;
    } cdb_ent_t;

    cdb_ent_t   in_ent [3];
    cdb_ent_t   buf_q  [3];
    logic [2:0] in_valid;
    logic [2:0] full_q;
    logic [2:0] keep;
    logic [2:0] in_young;
    logic [2:0] grant;
    logic [2:0] ready;
    logic [2:0] accept;
    logic [1:0] rr_ptr;
    logic [1:0] gnt_idx;
    logic [1:0] p0, p1, p2;
    logic       gnt_any;

    // Ages are taken relative to rob_head so the compare survives index wrap.
    function automatic logic younger(
        input logic [4:0] rob,
        input logic [4:0] head,
        input logic [4:0] tag
    );
        logic [4:0] age_r;
        logic [4:0] age_t;
        age_r = rob - head;
        age_t = tag - head;
        return age_r > age_t;
    endfunction

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign in_valid = {br_valid, mem_valid, alu_valid};

    always_comb begin
        in_ent[0] = '{pd: alu_pd, rob: alu_rob, data: alu_data};
        in_ent[1] = '{pd: mem_pd, rob: mem_rob, data: mem_data};
        in_ent[2] = '{pd: br_pd,  rob: br_rob,  data: br_data};
    end

    always_comb begin
        keep     = '0;
        in_young = '0;
        for (int i = 0; i < 3; i++) begin
            keep[i] = full_q[i] &
                      !(flush_valid &
                        younger(buf_q[i].rob, rob_head, flush_tag));
            in_young[i] = flush_valid &
                          younger(in_ent[i].rob, rob_head, flush_tag);
        end
    end

    assign p0 = rr_ptr;
    assign p1 = inc3(p0);
    assign p2 = inc3(p1);

    always_comb begin
        gnt_any = 1'b1;
        gnt_idx = 2'd0;
        if (keep[p0])      gnt_idx = p0;
        else if (keep[p1]) gnt_idx = p1;
        else if (keep[p2]) gnt_idx = p2;
        else               gnt_any = 1'b0;
    end

    assign grant  = gnt_any ? (3'b001 << gnt_idx) : 3'b000;
    assign ready  = (~full_q | grant) & ~in_young;
    assign accept = in_valid & ready;

    assign alu_ready = ready[0];
    assign mem_ready = ready[1];
    assign br_ready  = ready[2];

    always_comb begin
        cdb_valid = gnt_any;
        cdb_pd    = '0;
        cdb_rob   = '0;
        cdb_data  = '0;
        cdb_src   = '0;
        if (gnt_any) begin
            cdb_pd   = buf_q[gnt_idx].pd;
            cdb_rob  = buf_q[gnt_idx].rob;
            cdb_data = buf_q[gnt_idx].data;
            cdb_src  = gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= '0;
            rr_ptr <= 2'd0;
            for (int i = 0; i < 3; i++) buf_q[i] <= '0;
        end else begin
            if (gnt_any) rr_ptr <= inc3(gnt_idx);
            for (int i = 0; i < 3; i++) begin
                if (accept[i]) begin
                    full_q[i] <= 1'b1;
                    buf_q[i]  <= in_ent[i];
                end else if (grant[i] || !keep[i]) begin
                    full_q[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: single, contention, backpressure,
// wrap-around flush and mid-stream reset scenarios.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, mem_valid, br_valid;
    logic [6:0]  alu_pd, mem_pd, br_pd;
    logic [4:0]  alu_rob, mem_rob, br_rob;
    logic [31:0] alu_data, mem_data, br_data;
    logic        alu_ready, mem_ready, br_ready;
    logic        flush_valid;
    logic [4:0]  flush_tag;
    logic [4:0]  rob_head;
    logic        cdb_valid;
    logic [6:0]  cdb_pd;
    logic [4:0]  cdb_rob;
    logic [31:0] cdb_data;
    logic [1:0]  cdb_src;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_pd(alu_pd), .alu_rob(alu_rob),
        .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_pd(mem_pd), .mem_rob(mem_rob),
        .mem_data(mem_data), .mem_ready(mem_ready),
        .br_valid(br_valid), .br_pd(br_pd), .br_rob(br_rob),
        .br_data(br_data), .br_ready(br_ready),
        .flush_valid(flush_valid), .flush_tag(flush_tag),
        .rob_head(rob_head),
        .cdb_valid(cdb_valid), .cdb_pd(cdb_pd), .cdb_rob(cdb_rob),
        .cdb_data(cdb_data), .cdb_src(cdb_src)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        alu_valid = 0; alu_pd = 0; alu_rob = 0; alu_data = 0;
        mem_valid = 0; mem_pd = 0; mem_rob = 0; mem_data = 0;
        br_valid  = 0; br_pd  = 0; br_rob  = 0; br_data  = 0;
        flush_valid = 0; flush_tag = 0;
    endtask

    task automatic drive(input int s, input logic [6:0] pd,
                         input logic [4:0] rob, input logic [31:0] d);
        case (s)
            0: begin alu_valid = 1; alu_pd = pd; alu_rob = rob; alu_data = d; end
            1: begin mem_valid = 1; mem_pd = pd; mem_rob = rob; mem_data = d; end
            default: begin br_valid = 1; br_pd = pd; br_rob = rob; br_data = d; end
        endcase
    endtask

    task automatic chk_cdb(input string tag, input logic v,
                           input logic [6:0] pd, input logic [4:0] rob,
                           input logic [31:0] d, input logic [1:0] src);
        logic [46:0] got, exp;
        got = {cdb_valid, cdb_pd, cdb_rob, cdb_data, cdb_src};
        exp = {v, pd, rob, d, src};
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: cdb got v=%b pd=%0d rob=%0d data=%h src=%0d, expected v=%b pd=%0d rob=%0d data=%h src=%0d",
                   tag, cdb_valid, cdb_pd, cdb_rob, cdb_data, cdb_src,
                   v, pd, rob, d, src);
        end
    endtask

    task automatic chk_rdy(input string tag, input logic [2:0] exp);
        logic [2:0] got;
        got = {br_ready, mem_ready, alu_ready};
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: ready{br,mem,alu} got %b expected %b",
                   tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk_cdb(tag, 1'b0, 7'd0, 5'd0, 32'd0, 2'd0);
    endtask

    initial begin
        idle();
        rob_head = 0;
        rst_n = 0;
        #3;
        chk_idle("reset_cdb");
        chk_rdy("reset_ready", 3'b111);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        tick();

        // single ALU result, one-cycle latency
        drive(0, 7'd5, 5'd3, 32'hDEAD);
        #2;
        chk_idle("single_pre");
        chk_rdy("single_rdy", 3'b111);
        tick();
        idle();
        #2;
        chk_cdb("single_out", 1, 7'd5, 5'd3, 32'hDEAD, 2'd0);
        tick();
        #2;
        chk_idle("single_after");

        // single BR result brings rr_ptr back to 0
        drive(2, 7'd9, 5'd4, 32'h0B0B);
        tick();
        idle();
        #2;
        chk_cdb("br_single", 1, 7'd9, 5'd4, 32'h0B0B, 2'd2);
        tick();

        // three-way contention
        drive(0, 7'd1, 5'd1, 32'h11);
        drive(1, 7'd2, 5'd2, 32'h22);
        drive(2, 7'd3, 5'd3, 32'h33);
        tick();
        idle();
        #2;
        chk_cdb("cont_1", 1, 7'd1, 5'd1, 32'h11, 2'd0);
        chk_rdy("cont_1_rdy", 3'b001);
        tick();
        #2;
        chk_cdb("cont_2", 1, 7'd2, 5'd2, 32'h22, 2'd1);
        tick();
        #2;
        chk_cdb("cont_3", 1, 7'd3, 5'd3, 32'h33, 2'd2);
        tick();
        #2;
        chk_idle("cont_done");

        // backpressure with back-to-back refill
        drive(0, 7'd10, 5'd5, 32'hA1);
        drive(1, 7'd11, 5'd6, 32'hB1);
        tick();
        idle();
        drive(0, 7'd12, 5'd7, 32'hA2);
        #2;
        chk_cdb("bp_a", 1, 7'd10, 5'd5, 32'hA1, 2'd0);
        chk_rdy("bp_a_rdy", 3'b101);
        tick();
        idle();
        drive(0, 7'd13, 5'd8, 32'hA3);
        drive(1, 7'd14, 5'd9, 32'hB2);
        #2;
        chk_cdb("bp_b", 1, 7'd11, 5'd6, 32'hB1, 2'd1);
        chk_rdy("bp_b_rdy", 3'b110);
        tick();
        idle();
        #2;
        chk_cdb("bp_c", 1, 7'd12, 5'd7, 32'hA2, 2'd0);
        tick();
        #2;
        chk_cdb("bp_d", 1, 7'd14, 5'd9, 32'hB2, 2'd1);
        tick();
        #2;
        chk_idle("bp_done");

        // flush across the rob index wrap, rr_ptr = 2
        rob_head = 5'd30;
        drive(0, 7'd20, 5'd31, 32'hC1);
        drive(1, 7'd21, 5'd2,  32'hC2);
        drive(2, 7'd22, 5'd0,  32'hC3);
        tick();
        idle();
        flush_valid = 1;
        flush_tag   = 5'd0;
        #2;
        chk_cdb("flush_gnt", 1, 7'd22, 5'd0, 32'hC3, 2'd2);
        chk_rdy("flush_rdy", 3'b100);
        drive(2, 7'd23, 5'd5, 32'hC4);
        #1;
        chk_rdy("flush_refuse", 3'b000);
        tick();
        idle();
        #2;
        chk_cdb("flush_alu", 1, 7'd20, 5'd31, 32'hC1, 2'd0);
        tick();
        #2;
        chk_idle("flush_no_mem");

        // asynchronous reset with all buffers full, rr_ptr = 1
        rob_head = 5'd0;
        tick();
        drive(0, 7'd30, 5'd1, 32'hE1);
        drive(1, 7'd31, 5'd2, 32'hE2);
        drive(2, 7'd32, 5'd3, 32'hE3);
        tick();
        idle();
        #2;
        chk_cdb("rst_pre", 1, 7'd31, 5'd2, 32'hE2, 2'd1);
        rst_n = 0;
        #1;
        chk_idle("rst_cdb");
        chk_rdy("rst_rdy", 3'b111);
        @(negedge clk);
        rst_n = 1;
        tick();
        #2;
        chk_idle("rst_post_1");
        chk_rdy("rst_post_rdy", 3'b111);
        tick();
        #2;
        chk_idle("rst_post_2");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
